// File: rtl/spi_slave_rx_tx_if.sv
// spi_slave_rx_tx_if: bundle of the SPI pins and the local receive/transmit
// handshake signals of the byte-oriented SPI slave.
//   slave  modport : the view seen by spi_slave_rx_tx
//   master modport : the view seen by whatever drives the link and the local side
// Signals:
//   sclk, mosi              SPI clock and data from the link master
//   miso                    SPI data back to the link master
//   rx_data/rx_valid/rx_ready/rx_overrun/ovr_clr   receive holding register port
//   tx_data/tx_load/tx_empty                       transmit holding register port
//   busy, frame_err         byte in progress, timeout abort pulse
interface spi_slave_rx_tx_if;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       ovr_clr;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_empty;
  logic       busy;
  logic       frame_err;

  modport slave (
    input  sclk, mosi, rx_ready, ovr_clr, tx_data, tx_load,
    output miso, rx_data, rx_valid, rx_overrun, tx_empty, busy, frame_err
  );

  modport master (
    output sclk, mosi, rx_ready, ovr_clr, tx_data, tx_load,
    input  miso, rx_data, rx_valid, rx_overrun, tx_empty, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: byte-oriented SPI slave (mode 0, MSB first). sclk/mosi are
// oversampled in the clk domain, received bytes land in a single-entry
// valid/ready holding register, one byte per frame is returned on miso from a
// single-entry transmit holding register.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    spi_slave_rx_tx_if.slave (SPI pins, rx/tx holding ports, status)
// Parameters:
//   SYNC_STAGES  synchronizer depth for sclk and mosi (>= 2)
//   TIMEOUT      idle clk cycles mid-byte before the byte is aborted
// Optional feature: define SPI_SLAVE_TIMEOUT_EN to build the mid-byte timeout
// (frame_err pulses on abort); otherwise frame_err is tied low.
module spi_slave_rx_tx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input logic               clk,
  input logic               rst_n,
  spi_slave_rx_tx_if.slave  bus
);

  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("spi_slave_rx_tx: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  // Input synchronizers; equal depth keeps mosi aligned with sclk
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign fall   = ~sclk_s & sclk_prev_q;

  // Datapath state
  logic [2:0] bitcnt_q,   bitcnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q,  tx_hold_d;
  logic       tx_empty_q, tx_empty_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q,   rx_ovr_d;
  logic       miso_q,     miso_d;
  logic       busy_q,     busy_d;
  logic       ferr_q,     ferr_d;
  logic       byte_done;
  logic       ovr_set;

`ifdef SPI_SLAVE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  // Next-state for receive, transmit and status
  always_comb begin
    bitcnt_d   = bitcnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ferr_d     = 1'b0;
    byte_done  = 1'b0;
    ovr_set    = 1'b0;
`ifdef SPI_SLAVE_TIMEOUT_EN
    to_d       = to_q;
`endif

    if (rise) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s};
      bitcnt_d   = bitcnt_q + 3'(1);
      byte_done  = (bitcnt_q == 3'd7);
      // First rise of a byte consumes the holding register (idle-high if empty)
      if (bitcnt_q == 3'd0) begin
        tx_shift_d = tx_empty_q ? 8'hFF : tx_hold_q;
        tx_empty_d = 1'b1;
      end
    end else if (fall && bitcnt_q != 3'd0) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end

`ifdef SPI_SLAVE_TIMEOUT_EN
    // Idle counter runs only mid-byte; reaching TIMEOUT abandons the partial byte
    if (rise || fall || bitcnt_q == 3'd0) begin
      to_d = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end
    if (to_q == TO_W'(TIMEOUT)) begin
      bitcnt_d   = 3'd0;
      rx_shift_d = 8'h00;
      ferr_d     = 1'b1;
      byte_done  = 1'b0;
      to_d       = '0;
    end
`endif

    // Applied after the first-rise capture so a coincident load stays pending
    if (bus.tx_load) begin
      tx_hold_d  = bus.tx_data;
      tx_empty_d = 1'b0;
    end

    if (byte_done) begin
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = rx_shift_d;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    rx_ovr_d = ovr_set | (rx_ovr_q & ~bus.ovr_clr);

    // miso registered from next-state so it tracks tx_shift with no extra lag
    if (bitcnt_d != 3'd0) begin
      miso_d = tx_shift_d[7];
    end else begin
      miso_d = tx_empty_d ? 1'b1 : tx_hold_d[7];
    end
    busy_d = (bitcnt_d != 3'd0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
      tx_hold_q  <= 8'h00;
      tx_empty_q <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      miso_q     <= 1'b1;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      bitcnt_q   <= bitcnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_empty_q <= tx_empty_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef SPI_SLAVE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
  assign bus.frame_err = ferr_q;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.miso       = miso_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_ovr_q;
  assign bus.tx_empty   = tx_empty_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/spi_slave_rx_tx.md
# spi_slave_rx_tx

Byte-oriented SPI slave on the link driven by the team's SPI master, sitting at the far end of the link as its downstream peer. It oversamples `sclk`/`mosi` in the local `clk` domain, assembles MSB-first bytes, and returns one byte per frame on `miso`. The local logic sees a valid/ready receive port, a single-entry transmit holding register, and error flags.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `sclk` and `mosi`; legal values are 2 or more.
- `TIMEOUT`, 64: number of `clk` cycles without an `sclk` edge, mid-byte, before the byte is aborted.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `sclk` in 1: SPI clock from the master; asynchronous to `clk`; idles low.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `rx_overrun` out 1: sticky; a byte was lost.
- `ovr_clr` in 1: clears `rx_overrun`.
- `tx_data` in 8: next byte to transmit.
- `tx_load` in 1: write `tx_data` into the holding register.
- `tx_empty` out 1: holding register is free.
- `busy` out 1: a byte is in progress (bit count is nonzero).
- `frame_err` out 1: one-cycle pulse when a byte is aborted by timeout.

## Operation
- Synchronization:
  - `sclk` and `mosi` each pass through `SYNC_STAGES` flops, reset to 0.
  - A rise is synced sclk going 0 to 1; a fall is synced sclk going 1 to 0.
  - `mosi` and `sclk` are delayed by the same number of stages, so they stay aligned.
- Receive:
  - On each rise: `rx_shift <= {rx_shift[6:0], mosi_s}` and `bitcnt <= bitcnt + 1`.
  - `bitcnt` is 3 bits wide. On the 8th rise it wraps to 0 and the byte is complete.
- Receive holding register:
  - On byte complete, if `rx_valid` is 0, or `rx_valid & rx_ready` in the same cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: the new byte is discarded, `rx_data` is kept, and `rx_overrun` is set.
  - `rx_valid & rx_ready` with no completing byte clears `rx_valid`.
  - `ovr_clr` clears `rx_overrun`. If an overrun event and `ovr_clr` occur in the same cycle, set wins.
- Transmit:
  - While `bitcnt == 0`, `miso` = `tx_hold[7]` if the holding register is full, else 1.
  - On the first rise of a byte: `tx_shift <= full ? tx_hold : 8'hFF`, and `tx_empty` is set.
  - On each fall while `bitcnt != 0`: `tx_shift <= tx_shift << 1`.
  - While `bitcnt != 0`, `miso` = `tx_shift[7]`.
- `tx_load`:
  - Writes `tx_hold` and clears `tx_empty`.
  - If the holding register is already full, the previous data is overwritten (last write wins).
  - If `tx_load` coincides with a first rise, the old holding value is shifted out and the new value stays pending with `tx_empty` = 0.
- `busy` = (`bitcnt != 0`).

## Timing
- Reset values: `miso` = 1, `rx_data` = 0, `rx_valid` = 0, `rx_overrun` = 0, `tx_empty` = 1, `busy` = 0, `frame_err` = 0. All internal counters and shift registers reset to 0.
- `rx_valid` rises `SYNC_STAGES` + 1 `clk` cycles after the 8th `sclk` rising edge at the pin.
- `miso` changes `SYNC_STAGES` + 1 cycles after an `sclk` falling edge at the pin. The master samples it on the next rise.
- Link constraint: `sclk` high and low phases must each be at least `SYNC_STAGES` + 2 `clk` cycles. The master's clock divider must be set accordingly.
- `rst_n` asserted mid-byte: the partial byte is lost and all state returns to reset values immediately.

## Configuration
- Macro: `SPI_SLAVE_TIMEOUT_EN`.
- Defined:
  - A counter of width ceil(log2(`TIMEOUT`+1)) clears on any synced edge and on `bitcnt == 0`, and increments otherwise.
  - When it reaches `TIMEOUT`: `bitcnt <= 0`, `rx_shift` is discarded, and `frame_err` pulses for one cycle.
  - `tx_empty` and `tx_hold` are not affected by the abort.
- Not defined:
  - No timeout counter is built and `frame_err` is tied to 0.
  - Byte alignment is recovered only through `rst_n`.

## Test plan
- Master sends 0xA5 with the slave holding 0x3C → `rx_data` = 0xA5 with `rx_valid` = 1, the master receives 0x3C, `tx_empty` returns to 1.
- Two bytes 0x11, 0x22 with `rx_ready` held at 0 → `rx_data` stays 0x11 and `rx_overrun` = 1. Pulse `ovr_clr` → `rx_overrun` = 0.
- No `tx_load` before a frame → the master receives 0xFF.
- `tx_load` 0x55 on the cycle of the first synced rise while 0x66 is already held → 0x66 is shifted out, 0x55 remains pending, `tx_empty` = 0.
- With the macro defined, 3 bits sent, then `sclk` idle for 70 cycles → `frame_err` pulses once and `busy` = 0. A following 0xC3 byte is received intact. With the macro not defined, `frame_err` stays at 0 throughout.
- `rst_n` pulsed after 5 bits → all outputs at reset values. A following 0x81 byte is received correctly.
